// File: rtl/rr_arbiter_4.sv
// Four-client round-robin arbiter with registered one-hot grant, binary owner index,
// per-owner hold limit and a one-cycle timeout pulse when the limit revokes a grant.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      grant_reg, grant_next;
    logic [1:0]      idx_reg, idx_next;
    logic [1:0]      last_reg, last_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            timeout_reg, timeout_next;

    logic [3:0]      rot_req;
    logic [1:0]      rot_off;
    logic            any_req;
    logic [1:0]      winner;
    logic [3:0]      winner_onehot;
    logic            owner_req;
    logic            hold_done;

    // rot_req[0] is the client right after the last owner, so the lowest set bit wins.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rotate
            assign rot_req[gi] = req[last_reg + 2'(gi + 1)];
        end
    endgenerate

    always_comb begin
        rot_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_req[k]) begin
                rot_off = 2'(k);
            end
        end
    end

    assign any_req = |req;
    assign winner  = last_reg + rot_off + 2'd1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
            assign winner_onehot[gi] = (winner == 2'(gi));
        end
    endgenerate

    assign owner_req = req[idx_reg];
    assign hold_done = (cnt_reg == CW'(MAX_HOLD));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            grant_reg   <= 4'b0000;
            idx_reg     <= 2'd0;
            last_reg    <= 2'd3;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            idx_reg     <= idx_next;
            last_reg    <= last_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        idx_next     = idx_reg;
        last_next    = last_reg;
        cnt_next     = cnt_reg;
        timeout_next = 1'b0;

        if (!en) begin
            // Disable drops any owner quietly; it still counts as the last owner.
            if (state_reg == BUSY) begin
                last_next = idx_reg;
            end
            state_next = IDLE;
            grant_next = 4'b0000;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        state_next = BUSY;
                        grant_next = winner_onehot;
                        idx_next   = winner;
                        cnt_next   = CW'(1);
                    end
                end
                BUSY: begin
                    if (!owner_req || hold_done) begin
                        // A release on the limit cycle wins over the timeout.
                        state_next   = IDLE;
                        grant_next   = 4'b0000;
                        last_next    = idx_reg;
                        cnt_next     = '0;
                        timeout_next = owner_req;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    grant_next = 4'b0000;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign grant       = grant_reg;
    assign grant_idx   = idx_reg;
    assign grant_valid = |grant_reg;
    assign timeout     = timeout_reg;

endmodule
